// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch controller bus: button pulses and preset in, digit counter bank
// strobes/data out, plus display and status. clk/reset stay plain ports.
//   slave  : the stopwatch_ctrl side
//   master : the button/counter-bank/display side (or a testbench)
interface stopwatch_ctrl_if;
    logic        start_stop;
    logic        clear;
    logic        lap;
    logic [15:0] preset_val;
    logic [15:0] digit_q;
    logic [3:0]  digit_load;
    logic [3:0]  digit_count;
    logic [15:0] digit_d;
    logic [15:0] display;
    logic [1:0]  state;
    logic        lap_hold;
    logic        overflow;
    logic        tick;

    modport slave (
        input  start_stop, clear, lap, preset_val, digit_q,
        output digit_load, digit_count, digit_d, display, state,
               lap_hold, overflow, tick
    );

    modport master (
        output start_stop, clear, lap, preset_val, digit_q,
        input  digit_load, digit_count, digit_d, display, state,
               lap_hold, overflow, tick
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer for four cascaded BCD digit counters (SS.hh).
// Generates the hundredth-second tick, runs the IDLE/RUN/PAUSE machine,
// drives per-digit load/count/data strobes, and provides lap freeze and a
// sticky overflow flag.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   bus (slave)       : start_stop/clear/lap pulses, preset_val, digit_q in;
//                       digit_load/digit_count/digit_d, display, state,
//                       lap_hold, overflow, tick out
module stopwatch_ctrl #(
    parameter int unsigned TICK_DIV = 100000
) (
    input  logic            clk,
    input  logic            reset,
    stopwatch_ctrl_if.slave bus
);
    localparam int unsigned        PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0]      PRESC_MAX = PW'(TICK_DIV - 1);
    // Per-digit maxima {s_tens, s_ones, tenths, hundredths}
    localparam logic [15:0]        DIGIT_MAX = 16'h5999;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          overflow_q, overflow_d;
    logic          lap_hold_q, lap_hold_d;
    logic [15:0]   lap_val_q, lap_val_d;

    logic          tick_c;
    logic [3:0]    at_max;
    logic [3:0]    en;
    logic [3:0]    load_c;
    logic [3:0]    count_c;
    logic [15:0]   d_c;

    // Tick, carry chain and digit strobes; nothing is strobed in a reset cycle
    always_comb begin
        tick_c  = (state_q == ST_RUN) && (presc_q == PRESC_MAX) && !reset;
        load_c  = '0;
        count_c = '0;
        d_c     = '0;
        for (int i = 0; i < 4; i++) begin
            // codes above the maximum count as "at max" so they wrap to 0
            at_max[i] = (bus.digit_q[4*i +: 4] >= DIGIT_MAX[4*i +: 4]);
        end
        en[0] = tick_c;
        en[1] = tick_c && at_max[0];
        en[2] = tick_c && at_max[0] && at_max[1];
        en[3] = tick_c && at_max[0] && at_max[1] && at_max[2];

        if (!reset) begin
            if (bus.clear) begin
                load_c = 4'b1111;
                for (int i = 0; i < 4; i++) begin
                    if (bus.preset_val[4*i +: 4] <= DIGIT_MAX[4*i +: 4]) begin
                        d_c[4*i +: 4] = bus.preset_val[4*i +: 4];
                    end
                end
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (en[i]) begin
                        if (at_max[i]) begin
                            load_c[i] = 1'b1;
                        end else begin
                            count_c[i] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Next-state logic for the FSM, prescaler, overflow and lap registers
    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        overflow_d = overflow_q;
        lap_hold_d = lap_hold_q;
        lap_val_d  = lap_val_q;

        if (bus.clear) begin
            state_d    = ST_IDLE;
            presc_d    = '0;
            overflow_d = 1'b0;
            lap_hold_d = 1'b0;
            lap_val_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    presc_d = '0;
                    if (bus.start_stop) state_d = ST_RUN;
                end
                ST_RUN: begin
                    presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
                    if (bus.start_stop) state_d = ST_PAUSE;
                end
                ST_PAUSE: begin
                    if (bus.start_stop) state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_IDLE;
                    presc_d = '0;
                end
            endcase

            if (tick_c && (&at_max)) overflow_d = 1'b1;

            if (bus.lap) begin
                if (state_q == ST_RUN) begin
                    lap_val_d  = bus.digit_q;
                    lap_hold_d = 1'b1;
                end else begin
                    lap_hold_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            presc_q    <= '0;
            overflow_q <= 1'b0;
            lap_hold_q <= 1'b0;
            lap_val_q  <= '0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            overflow_q <= overflow_d;
            lap_hold_q <= lap_hold_d;
            lap_val_q  <= lap_val_d;
        end
    end

    assign bus.digit_load  = load_c;
    assign bus.digit_count = count_c;
    assign bus.digit_d     = d_c;
    assign bus.tick        = tick_c;
    assign bus.state       = state_q;
    assign bus.overflow    = overflow_q;
    assign bus.lap_hold    = lap_hold_q;
    assign bus.display     = lap_hold_q ? lap_val_q : bus.digit_q;
endmodule
